// File: rtl/call_return_pkg.sv
// Shared types and defaults for the CALL/RET redirect controller.
package call_return_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CALL,
      POP,
      CAPT,
      LOAD
   } state_t;

   localparam int DEF_WIDTH_DATA = 32;
   localparam int DEF_RET_OFFSET = 1;

endpackage

// File: rtl/call_return_ctrl.sv
// CALL/RET to return-stack push/pop + PC redirect; CALL redirects 1 cycle after accept, RET 3 cycles.
// Accepts only in IDLE with busy low; full/empty refusals set sticky error flags instead of touching the stack.
module call_return_ctrl
   import call_return_pkg::*;
#(
   parameter int WIDTH_DATA = DEF_WIDTH_DATA,
   parameter int RET_OFFSET = DEF_RET_OFFSET
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  call_req,
   input  logic                  ret_req,
   input  logic [WIDTH_DATA-1:0] pc_current,
   input  logic [WIDTH_DATA-1:0] call_target,
   output logic                  busy,
   output logic                  pc_load,
   output logic [WIDTH_DATA-1:0] pc_next,
   output logic                  stack_push,
   output logic                  stack_pop,
   output logic [WIDTH_DATA-1:0] stack_data,
   input  logic [WIDTH_DATA-1:0] stack_q,
   input  logic                  stack_full,
   input  logic                  stack_empty,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   localparam logic [WIDTH_DATA-1:0] OFFSET = WIDTH_DATA'(RET_OFFSET);

   state_t                  state, state_nxt;
   logic                    busy_nxt, pc_load_nxt, push_nxt, pop_nxt;
   logic                    ovf_nxt, udf_nxt;
   logic [WIDTH_DATA-1:0]   pc_next_nxt, stack_data_nxt;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Outputs are computed one state ahead so every strobe leaves a flop.
   always_comb begin
      state_nxt      = state;
      busy_nxt       = 1'b0;
      pc_load_nxt    = 1'b0;
      push_nxt       = 1'b0;
      pop_nxt        = 1'b0;
      pc_next_nxt    = pc_next;
      stack_data_nxt = stack_data;
      ovf_nxt        = overflow_err;
      udf_nxt        = underflow_err;
      case (state)
         IDLE: begin
            if (call_req) begin
               if (stack_full) begin
                  ovf_nxt = 1'b1;
               end else begin
                  state_nxt      = CALL;
                  busy_nxt       = 1'b1;
                  push_nxt       = 1'b1;
                  pc_load_nxt    = 1'b1;
                  stack_data_nxt = pc_current + OFFSET;
                  pc_next_nxt    = call_target;
               end
            end else if (ret_req) begin
               if (stack_empty) begin
                  udf_nxt = 1'b1;
               end else begin
                  state_nxt = POP;
                  busy_nxt  = 1'b1;
                  pop_nxt   = 1'b1;
               end
            end
         end
         CALL: state_nxt = IDLE;
         POP: begin
            state_nxt = CAPT;
            busy_nxt  = 1'b1;
         end
         // stack_q is valid during this state, one cycle after the pop strobe.
         CAPT: begin
            state_nxt   = LOAD;
            busy_nxt    = 1'b1;
            pc_load_nxt = 1'b1;
            pc_next_nxt = stack_q;
         end
         LOAD: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy          <= 1'b0;
         pc_load       <= 1'b0;
         stack_push    <= 1'b0;
         stack_pop     <= 1'b0;
         pc_next       <= '0;
         stack_data    <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         busy          <= busy_nxt;
         pc_load       <= pc_load_nxt;
         stack_push    <= push_nxt;
         stack_pop     <= pop_nxt;
         pc_next       <= pc_next_nxt;
         stack_data    <= stack_data_nxt;
         overflow_err  <= ovf_nxt;
         underflow_err <= udf_nxt;
      end
   end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Bench for call_return_ctrl: behavioural stack, cycle-indexed expectation model, directed CALL/RET sequences.
module tb_call_return_ctrl;

   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int NCYC  = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, call_req, ret_req;
   logic [W-1:0] pc_current, call_target;
   logic         busy, pc_load, stack_push, stack_pop;
   logic [W-1:0] pc_next, stack_data;
   logic [W-1:0] stack_q = '0;
   logic         stack_full, stack_empty;
   logic         overflow_err, underflow_err;

   call_return_ctrl #(.WIDTH_DATA(W), .RET_OFFSET(1)) dut (
      .clk(clk), .reset(reset), .call_req(call_req), .ret_req(ret_req),
      .pc_current(pc_current), .call_target(call_target), .busy(busy),
      .pc_load(pc_load), .pc_next(pc_next), .stack_push(stack_push),
      .stack_pop(stack_pop), .stack_data(stack_data), .stack_q(stack_q),
      .stack_full(stack_full), .stack_empty(stack_empty),
      .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   // Return-address stack with registered read data.
   logic [W-1:0] stk[$];
   int           cnt = 0;
   logic         force_full = 1'b0, force_empty = 1'b0;
   assign stack_full  = force_full || (cnt >= DEPTH);
   assign stack_empty = force_empty || (cnt == 0);

   always @(posedge clk) begin
      if (stack_push) stk.push_back(stack_data);
      if (stack_pop && stk.size() > 0) begin
         stack_q <= stk[$];
         stk.pop_back();
      end
      cnt <= stk.size();
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   // Expected outputs per cycle index (cycle N is the one following rising edge N).
   int           cyc = 0;
   bit           armed = 1'b0;
   int           idle_from = 0;
   bit           e_busy [NCYC];
   bit           e_push [NCYC];
   bit           e_pop  [NCYC];
   bit           e_load [NCYC];
   logic [W-1:0] e_nx   [NCYC];
   logic [W-1:0] e_dat  [NCYC];
   bit           m_ov = 1'b0, m_un = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (cyc + 4 >= NCYC) begin
         $display("FAIL cycle_budget t=%0t got=%0d want<%0d", $time, cyc, NCYC - 4);
         $fatal(1, "cycle budget exhausted");
      end
      if (!reset) begin
         armed = 1'b1;
         for (int k = 0; k < 4; k++) begin
            e_busy[cyc+k] = 1'b0;
            e_push[cyc+k] = 1'b0;
            e_pop[cyc+k]  = 1'b0;
            e_load[cyc+k] = 1'b0;
         end
         m_ov = 1'b0;
         m_un = 1'b0;
         idle_from = cyc + 1;
      end else if (armed && cyc >= idle_from) begin
         if (call_req) begin
            if (stack_full) m_ov = 1'b1;
            else begin
               e_busy[cyc] = 1'b1;
               e_push[cyc] = 1'b1;
               e_load[cyc] = 1'b1;
               e_dat[cyc]  = pc_current + 1;
               e_nx[cyc]   = call_target;
               idle_from   = cyc + 2;
            end
         end else if (ret_req) begin
            if (stack_empty) m_un = 1'b1;
            else begin
               e_pop[cyc]    = 1'b1;
               e_busy[cyc]   = 1'b1;
               e_busy[cyc+1] = 1'b1;
               e_busy[cyc+2] = 1'b1;
               e_load[cyc+2] = 1'b1;
               e_nx[cyc+2]   = (stk.size() > 0) ? stk[$] : 'x;
               idle_from     = cyc + 4;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("busy",          W'(busy),          W'(e_busy[cyc]));
         chk("pc_load",       W'(pc_load),       W'(e_load[cyc]));
         chk("stack_push",    W'(stack_push),    W'(e_push[cyc]));
         chk("stack_pop",     W'(stack_pop),     W'(e_pop[cyc]));
         chk("overflow_err",  W'(overflow_err),  W'(m_ov));
         chk("underflow_err", W'(underflow_err), W'(m_un));
         if (e_load[cyc]) chk("pc_next", pc_next, e_nx[cyc]);
         if (e_push[cyc]) chk("stack_data", stack_data, e_dat[cyc]);
      end
   end

   // Drive one cycle of inputs, then return at the following falling edge.
   task automatic drv(input logic c, input logic r, input logic [W-1:0] pc,
                      input logic [W-1:0] tg, input logic rs);
      #1;
      call_req    = c;
      ret_req     = r;
      pc_current  = pc;
      call_target = tg;
      reset       = rs;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1'b0, 1'b0, $urandom, $urandom, 1'b1);
   endtask

   initial begin
      logic [W-1:0] pcs [3];
      pcs[0] = 32'h0000_0300;
      pcs[1] = 32'hFFFF_FFFF;
      pcs[2] = 32'h0000_0500;
      reset = 1'b0; call_req = 1'b0; ret_req = 1'b0;
      pc_current = '0; call_target = '0;
      @(negedge clk);
      drv(0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0);
      chk("rst_busy",    W'(busy),          0);
      chk("rst_pc_next", pc_next,           0);
      chk("rst_sdata",   stack_data,        0);
      chk("rst_ovf",     W'(overflow_err),  0);
      chk("rst_udf",     W'(underflow_err), 0);
      idle(1);

      // Plain CALL; inputs are scrambled afterwards to test latching.
      drv(1, 0, 32'h100, 32'h400, 1);
      chk("call_push",  W'(stack_push), 1);
      chk("call_sdata", stack_data,     32'h101);
      chk("call_load",  W'(pc_load),    1);
      chk("call_pcnxt", pc_next,        32'h400);
      chk("call_busy",  W'(busy),       1);
      idle(1);
      chk("call_busy_end", W'(busy), 0);

      // RET of the address just pushed.
      drv(0, 1, $urandom, $urandom, 1);
      chk("ret_pop",  W'(stack_pop), 1);
      chk("ret_busy", W'(busy),      1);
      idle(1);
      chk("ret_noload", W'(pc_load), 0);
      idle(1);
      chk("ret_load",  W'(pc_load), 1);
      chk("ret_pcnxt", pc_next,     32'h101);
      idle(1);
      chk("ret_busy_end", W'(busy), 0);

      // Underflow, then a CALL accepted in the very next cycle.
      drv(0, 1, $urandom, $urandom, 1);
      chk("udf_flag", W'(underflow_err), 1);
      chk("udf_busy", W'(busy),          0);
      drv(1, 0, 32'h200, 32'h800, 1);
      chk("udf_next_busy",  W'(busy),          1);
      chk("udf_next_sdata", stack_data,        32'h201);
      chk("udf_sticky",     W'(underflow_err), 1);

      // Back-to-back CALLs with RETs issued while busy (ignored), incl. PC wrap.
      drv(0, 1, $urandom, $urandom, 1);
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, pcs[i], 32'h1000 + 32'(i), 1);
         if (i == 1) chk("wrap_sdata", stack_data, 32'h0);
         drv(0, 1, $urandom, $urandom, 1);
      end

      // Stack now full: overflow refusal.
      drv(1, 0, 32'h600, 32'h900, 1);
      chk("ovf_flag", W'(overflow_err), 1);
      chk("ovf_push", W'(stack_push),   0);
      chk("ovf_busy", W'(busy),         0);

      for (int i = 0; i < 2; i++) begin
         drv(0, 1, $urandom, $urandom, 1);
         idle(3);
      end

      // Simultaneous CALL and RET: CALL wins, no pop.
      drv(1, 1, 32'h700, 32'hA00, 1);
      chk("both_push",  W'(stack_push), 1);
      chk("both_pop",   W'(stack_pop),  0);
      chk("both_sdata", stack_data,     32'h701);
      idle(4);

      drv(0, 0, 0, 0, 0);
      chk("rst2_ovf", W'(overflow_err),  0);
      chk("rst2_udf", W'(underflow_err), 0);
      idle(1);

      // Reset while in CAPT aborts the RET.
      drv(0, 1, $urandom, $urandom, 1);
      idle(1);
      drv(0, 0, $urandom, $urandom, 0);
      chk("abort_load",  W'(pc_load), 0);
      chk("abort_busy",  W'(busy),    0);
      chk("abort_pcnxt", pc_next,     0);
      idle(4);

      force_empty = 1'b1;
      drv(0, 1, $urandom, $urandom, 1);
      chk("fempty_udf", W'(underflow_err), 1);
      force_empty = 1'b0;

      drv(0, 1, $urandom, $urandom, 1);
      idle(2);
      chk("last_load",  W'(pc_load), 1);
      chk("last_pcnxt", pc_next,     32'h301);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/call_return_ctrl.md
# call_return_ctrl

Control stage that sits directly upstream of the processor's hardware return-address stack. It turns decoded CALL/RET requests into stack push/pop strobes and drives a PC redirect:
- CALL jumps to the target.
- RET jumps to the popped return address.

It absorbs the stack's one-cycle registered pop latency, stalls the front end while it works, and flags overflow and underflow instead of corrupting the stack.

## Interface
Parameters:
- WIDTH_DATA, 32, width of PC, targets and stack entries.
- RET_OFFSET, 1, added to pc_current to form the pushed return address.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- call_req  in  1  single-cycle CALL request from decode.
- ret_req  in  1  single-cycle RET request from decode.
- pc_current  in  WIDTH_DATA  PC of the requesting instruction.
- call_target  in  WIDTH_DATA  CALL destination address.
- busy  out  1  high while a request is in flight; front end must stall.
- pc_load  out  1  one-cycle PC redirect strobe.
- pc_next  out  WIDTH_DATA  redirect address; valid when pc_load=1.
- stack_push  out  1  push strobe to stack.
- stack_pop  out  1  pop strobe to stack.
- stack_data  out  WIDTH_DATA  return address to push.
- stack_q  in  WIDTH_DATA  stack read data; registered, valid the cycle after stack_pop.
- stack_full  in  1  stack cannot accept a push.
- stack_empty  in  1  stack holds no entry.
- overflow_err  out  1  sticky: CALL refused because the stack was full.
- underflow_err  out  1  sticky: RET refused because the stack was empty.

## Operation
- FSM states: IDLE, CALL, POP, CAPT, LOAD. All outputs are registered.
- Requests are accepted only in IDLE. Any request seen in another state is ignored (decode is stalled by busy).
- IDLE with call_req=1:
  - If stack_full=1: set overflow_err and stay in IDLE. No push, no pc_load.
  - Otherwise: go to CALL.
- CALL, one cycle:
  - stack_push=1 and stack_data = pc_current_latched + RET_OFFSET, computed mod 2^WIDTH_DATA (wraps).
  - pc_load=1 and pc_next = call_target_latched.
  - Next state: IDLE.
- IDLE with ret_req=1 and call_req=0:
  - If stack_empty=1: set underflow_err and stay in IDLE. No pop, no pc_load.
  - Otherwise: go to POP.
- POP: stack_pop=1 for exactly one cycle, then CAPT.
- CAPT: register stack_q into pc_next, then LOAD.
- LOAD: pc_load=1 for one cycle with the captured address, then IDLE.
- call_req and ret_req asserted together: the CALL is serviced and the RET is dropped; no error flag.
- stack_push and stack_pop are never asserted in the same cycle.
- pc_current and call_target are latched on acceptance. Later changes on these inputs do not affect the operation in flight.
- Error flags stay set until reset.

## Timing
- Reset (reset=0 at a rising edge):
  - State returns to IDLE.
  - busy, pc_load, stack_push, stack_pop, overflow_err and underflow_err are all 0.
  - pc_next and stack_data are 0.
  - Reset aborts any in-flight operation, even mid-sequence. A pending pop whose strobe was already issued is not replayed.
- CALL accepted at edge N:
  - stack_push and pc_load are high in cycle N+1.
  - busy is high in cycle N+1 only.
- RET accepted at edge N:
  - stack_pop is high in cycle N+1.
  - stack_q is sampled at the end of cycle N+2.
  - pc_load is high in cycle N+3.
  - busy is high in cycles N+1 to N+3.
- A refused request (error) gives no busy pulse. A new request is accepted in the very next cycle.
- Back-to-back throughput:
  - One CALL every 2 cycles.
  - One RET every 4 cycles.

## Structure
- Package call_return_pkg holds:
  - the FSM state enum (IDLE, CALL, POP, CAPT, LOAD);
  - the default WIDTH_DATA;
  - the default RET_OFFSET.
- Single flat module, no sub-modules. The adder and FSM are too small to split.

## Test plan
- Reset, then call_req with pc_current=0x100 and call_target=0x400 -> next cycle: stack_push=1, stack_data=0x101, pc_load=1, pc_next=0x400, busy=1.
- CALL as above, then ret_req with a stack model returning 0x101 -> stack_pop in cycle +1, pc_load=1 with pc_next=0x101 in cycle +3, busy high for 3 cycles.
- ret_req with stack_empty=1 -> underflow_err=1 and stays 1; no stack_pop or pc_load; the next call_req is accepted in the following cycle.
- call_req with stack_full=1 -> overflow_err=1, no stack_push; a later reset clears the flag.
- call_req and ret_req in the same cycle -> only the CALL sequence occurs; stack_pop is never asserted.
- Edge cases:
  - pc_current=0xFFFFFFFF on CALL -> stack_data=0x00000000 (wrap).
  - reset=0 during CAPT -> IDLE with all outputs 0 at the next edge; no pc_load.
